mem_system_banked: RTL and testbench

Parametrised, pipelined, byte-lane banked memory that serves the core and test benches as a drop-in, higher-fidelity replacement for the single-cycle 4-bank memory model. It has one request channel (read or write) with a valid/ready handshake. Read responses have a programmable latency and can be back-pressured through an in-order response queue. Writes are byte-enabled. Misaligned and out-of-range accesses are flagged instead of silently aliased.

---
 rtl/mem_system_banked_if.sv | 44 ++++
 rtl/mem_system_banked.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_system_banked.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_system_banked_if.sv
// -----------------------------------------------------------------------------
// mem_system_banked_if
//
// Request/response bundle for mem_system_banked.
//
// Request channel (master -> slave, valid/ready):
//   req_valid, wr, addr, data_in, byte_en   driven by the master
//   req_ready                               driven by the memory
// Response channel (slave -> master, valid/ready):
//   resp_valid, data_out, resp_err          driven by the memory
//   resp_ready                              driven by the master
//
// Parameters: DATA_W (multiple of 8), ADDR_W (byte address width).
// -----------------------------------------------------------------------------
interface mem_system_banked_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();

  localparam int BANKS = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [BANKS-1:0]  byte_en;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] data_out;
  logic              resp_err;

  modport master (
    output req_valid, wr, addr, data_in, byte_en, resp_ready,
    input  req_ready, resp_valid, data_out, resp_err
  );

  modport slave (
    input  req_valid, wr, addr, data_in, byte_en, resp_ready,
    output req_ready, resp_valid, data_out, resp_err
  );

endinterface

// File: rtl/mem_system_banked.sv
// -----------------------------------------------------------------------------
// mem_system_banked
//
// Pipelined byte-lane banked memory with one request channel and an in-order,
// back-pressurable read response queue.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (control state only; array untouched)
//   bus    mem_system_banked_if.slave
//            req_valid/req_ready/wr/addr/data_in/byte_en : request channel
//            resp_valid/resp_ready/data_out/resp_err     : read responses
//
// Parameters:
//   DATA_W      data width, multiple of 8; one 8-bit bank per byte lane
//   ADDR_W      byte address width
//   DEPTH_W     log2 of words per bank
//   READ_LAT    accept-to-response latency in cycles (1..4)
//   RESP_DEPTH  max reads accepted but not yet consumed (>= 1)
//
// Reads sample the array combinationally in the accept cycle, so a write
// accepted in the previous cycle is always visible and a later write can never
// disturb a read already in flight. The sampled word then walks READ_LAT-1
// pipeline registers and lands in the response FIFO at the READ_LAT-th edge.
// A credit counter covering pipeline + FIFO bounds reads in flight, which is
// why the FIFO needs no full check.
// -----------------------------------------------------------------------------
module mem_system_banked #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DEPTH_W    = 14,
  parameter int READ_LAT   = 2,
  parameter int RESP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_system_banked_if.slave bus
);

  localparam int BANKS  = DATA_W / 8;
  localparam int OFF    = $clog2(BANKS);
  localparam int WORDS  = 1 << DEPTH_W;
  localparam int PIPE_N = (READ_LAT > 1) ? READ_LAT - 1 : 1;
  localparam int PTR_W  = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RESP_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(RESP_DEPTH - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF) - 1);

  // FIFO depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) return '0;
    return p + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic               req_ready;
  logic               misaligned;
  logic               out_of_range;
  logic               req_err;
  logic               acc;
  logic               rd_acc;
  logic               wr_acc;
  logic [DEPTH_W-1:0] idx;
  logic [ADDR_W-1:0]  addr_hi;

  always_comb begin
    misaligned   = (bus.addr & OFF_MASK) != '0;
    addr_hi      = bus.addr >> (DEPTH_W + OFF);
    out_of_range = addr_hi != '0;
    req_err      = misaligned | out_of_range;
    idx          = bus.addr[DEPTH_W+OFF-1:OFF];
    acc          = bus.req_valid & req_ready;
    rd_acc       = acc & ~bus.wr;
    // Erroneous writes are dropped so they cannot alias onto a legal word.
    wr_acc       = acc & bus.wr & ~req_err;
  end

  // ---------------------------------------------------------------------------
  // Banked array (not reset)
  // ---------------------------------------------------------------------------
  logic [7:0]        mem [BANKS][WORDS];
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BANKS; i++) begin
      rd_word[8*i +: 8] = mem[i][idx];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BANKS; i++) begin
        if (bus.byte_en[i]) begin
          mem[i][idx] <= bus.data_in[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read latency pipeline
  // st_* index k is the value entering edge k+1 after accept; index 0 is the
  // accept cycle itself. The last index feeds the FIFO.
  // ---------------------------------------------------------------------------
  logic              st_vld  [READ_LAT];
  logic              st_err  [READ_LAT];
  logic [DATA_W-1:0] st_data [READ_LAT];

  logic              pipe_vld_q  [PIPE_N];
  logic              pipe_vld_d  [PIPE_N];
  logic              pipe_err_q  [PIPE_N];
  logic              pipe_err_d  [PIPE_N];
  logic [DATA_W-1:0] pipe_data_q [PIPE_N];
  logic [DATA_W-1:0] pipe_data_d [PIPE_N];

  always_comb begin
    st_vld[0]  = rd_acc;
    st_err[0]  = req_err;
    st_data[0] = req_err ? '0 : rd_word;
    for (int k = 1; k < READ_LAT; k++) begin
      st_vld[k]  = pipe_vld_q[k-1];
      st_err[k]  = pipe_err_q[k-1];
      st_data[k] = pipe_data_q[k-1];
    end
    for (int k = 0; k < PIPE_N; k++) begin
      pipe_vld_d[k]  = st_vld[k];
      pipe_err_d[k]  = st_err[k];
      pipe_data_d[k] = st_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_N; k++) pipe_vld_q[k] <= 1'b0;
    end else begin
      for (int k = 0; k < PIPE_N; k++) pipe_vld_q[k] <= pipe_vld_d[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < PIPE_N; k++) begin
      pipe_err_q[k]  <= pipe_err_d[k];
      pipe_data_q[k] <= pipe_data_d[k];
    end
  end

  // ---------------------------------------------------------------------------
  // In-order response FIFO
  // ---------------------------------------------------------------------------
  logic              enq;
  logic              hs;
  logic              resp_valid;
  logic [DATA_W-1:0] fifo_data [RESP_DEPTH];
  logic              fifo_err  [RESP_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;

  always_comb begin
    enq        = st_vld[READ_LAT-1];
    resp_valid = fifo_cnt_q != '0;
    hs         = resp_valid & bus.resp_ready;

    rd_ptr_d   = hs  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    fifo_cnt_d = fifo_cnt_q;
    if (enq && !hs)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
    else if (!enq && hs) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_data[wr_ptr_q] <= st_data[READ_LAT-1];
      fifo_err[wr_ptr_q]  <= st_err[READ_LAT-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Credit counter: reads accepted whose response is not yet consumed
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (rd_acc && !hs)      cnt_d = cnt_q + CNT_W'(1);
    else if (!rd_acc && hs) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      fifo_cnt_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ready depends only on registered credit, never on this cycle's handshakes.
  // FIFO storage is not reset, so the head is masked to zero while empty.
  // ---------------------------------------------------------------------------
  assign req_ready      = cnt_q < CNT_FULL;
  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.data_out   = resp_valid ? fifo_data[rd_ptr_q] : '0;
  assign bus.resp_err   = resp_valid & fifo_err[rd_ptr_q];

endmodule

// File: tb/tb_mem_system_banked.sv
module tb_mem_system_banked;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int DEPTH_W    = 14;
  localparam int READ_LAT   = 2;
  localparam int RESP_DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_system_banked_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_system_banked #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W),
    .READ_LAT(READ_LAT), .RESP_DEPTH(RESP_DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Contents written to word i (byte address 4*i) by the throughput test.
  function automatic logic [31:0] word_val(input int i);
    return 32'h01010101 * 32'(i + 1);
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.wr        = 1'b0;
    bus.addr      = '0;
    bus.data_in   = '0;
    bus.byte_en   = '0;
  endtask

  // Called just after a negedge with req_ready known high; returns one cycle later.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.req_valid = 1'b1;
    bus.wr        = 1'b1;
    bus.addr      = a;
    bus.data_in   = d;
    bus.byte_en   = be;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic issue_read(input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.wr        = 1'b0;
    bus.addr      = a;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, expected 1", bus.req_ready); end
    checks++;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b, expected 0", bus.resp_valid); end
    checks++;
    if (bus.data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h, expected 00000000", bus.data_out); end
    checks++;
    if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b, expected 0", bus.resp_err); end
  endtask

  task automatic test_byte_enable();
    bus.resp_ready = 1'b1;
    do_write(32'h10, 32'hAABBCCDD, 4'b1111);
    do_write(32'h10, 32'h11223344, 4'b0101);
    issue_read(32'h10);
    checks++;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL be_early_valid: got %b, expected 0 at N+1", bus.resp_valid); end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.data_out !== 32'hAA22CC44 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL be_read: valid=%b data=%h err=%b, expected valid=1 data=aa22cc44 err=0",
               bus.resp_valid, bus.data_out, bus.resp_err);
    end
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL be_drained: got %b, expected 0", bus.resp_valid); end
  endtask

  task automatic test_back_to_back();
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) do_write(32'(4 * i), word_val(i), 4'b1111);
    for (int k = 0; k < 8 + READ_LAT + 1; k++) begin
      checks++;
      if (k >= READ_LAT && k < 8 + READ_LAT) begin
        if (bus.resp_valid !== 1'b1 || bus.data_out !== word_val(k - READ_LAT) || bus.resp_err !== 1'b0) begin
          errors++;
          $display("FAIL b2b_resp[%0d]: valid=%b data=%h err=%b, expected valid=1 data=%h err=0",
                   k - READ_LAT, bus.resp_valid, bus.data_out, bus.resp_err, word_val(k - READ_LAT));
        end
      end else begin
        if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: valid=%b, expected 0", k, bus.resp_valid); end
      end
      if (k < 8) begin
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b, expected 1", k, bus.req_ready); end
        bus.req_valid = 1'b1;
        bus.wr        = 1'b0;
        bus.addr      = 32'(4 * k);
      end else begin
        idle_inputs();
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    int n_acc;
    n_acc = 0;
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bus.req_ready !== (k < RESP_DEPTH)) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b, expected %b", k, bus.req_ready, (k < RESP_DEPTH));
      end
      bus.req_valid = 1'b1;
      bus.wr        = 1'b0;
      bus.addr      = 32'(4 * n_acc);
      if (bus.req_ready === 1'b1) n_acc++;
      @(negedge clk);
    end
    idle_inputs();
    checks++;
    if (n_acc != RESP_DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d, expected %0d", n_acc, RESP_DEPTH); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.data_out !== word_val(0) || bus.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h ready=%b, expected valid=1 data=%h ready=0",
                 k, bus.resp_valid, bus.data_out, bus.req_ready, word_val(0));
      end
      @(negedge clk);
    end
    for (int k = 0; k < RESP_DEPTH; k++) begin
      checks++;
      if (bus.resp_valid !== 1'b1 || bus.data_out !== word_val(k)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: valid=%b data=%h, expected valid=1 data=%h", k, bus.resp_valid, bus.data_out, word_val(k));
      end
      if (k == 0) begin
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b, expected 0", bus.req_ready); end
      end
      if (k == 1) begin
        checks++;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_reopen: got %b, expected 1", bus.req_ready); end
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: valid=%b, expected 0", bus.resp_valid); end
  endtask

  task automatic test_errors();
    bus.resp_ready = 1'b1;
    issue_read(32'h13);
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL err_misaligned: valid=%b err=%b data=%h, expected valid=1 err=1 data=00000000",
               bus.resp_valid, bus.resp_err, bus.data_out);
    end
    @(negedge clk);
    do_write(32'h20, 32'h55667788, 4'b1111);
    do_write(32'h20 | (32'h1 << (DEPTH_W + 2)), 32'hDEADBEEF, 4'b1111);
    issue_read(32'h20);
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.data_out !== 32'h55667788) begin
      errors++;
      $display("FAIL err_alias_write: valid=%b err=%b data=%h, expected valid=1 err=0 data=55667788",
               bus.resp_valid, bus.resp_err, bus.data_out);
    end
    @(negedge clk);
    issue_read(32'h20 | (32'h1 << (DEPTH_W + 2)));
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL err_range_read: valid=%b err=%b data=%h, expected valid=1 err=1 data=00000000",
               bus.resp_valid, bus.resp_err, bus.data_out);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int n;
    bus.resp_ready = 1'b0;
    issue_read(32'h0);
    issue_read(32'h4);
    issue_read(32'h8);
    repeat (2) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b1 || bus.data_out !== word_val(0)) begin
      errors++;
      $display("FAIL sim_pre: ready=%b valid=%b data=%h, expected ready=1 valid=1 data=%h",
               bus.req_ready, bus.resp_valid, bus.data_out, word_val(0));
    end
    // Accept and handshake together at cnt = RESP_DEPTH-1.
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.wr         = 1'b0;
    bus.addr       = 32'hC;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1 || bus.data_out !== word_val(1)) begin
      errors++;
      $display("FAIL sim_after: ready=%b data=%h, expected ready=1 data=%h", bus.req_ready, bus.data_out, word_val(1));
    end
    // One more read must fill the credit exactly if cnt stayed put.
    bus.resp_ready = 1'b0;
    bus.addr       = 32'h10;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL sim_full: ready=%b, expected 0", bus.req_ready); end
    bus.resp_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.resp_valid === 1'b1) begin
        checks++;
        if (bus.data_out !== word_val(n + 1)) begin
          errors++;
          $display("FAIL sim_drain[%0d]: data=%h, expected %h", n, bus.data_out, word_val(n + 1));
        end
        n++;
      end
      @(negedge clk);
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL sim_count: got %0d responses, expected 4", n); end
  endtask

  task automatic test_mid_reset();
    bus.resp_ready = 1'b0;
    issue_read(32'h0);
    issue_read(32'h4);
    issue_read(32'h8);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.data_out !== 32'h0 || bus.resp_err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outputs: ready=%b valid=%b data=%h err=%b, expected 1 0 00000000 0",
               bus.req_ready, bus.resp_valid, bus.data_out, bus.resp_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: valid=%b, expected 0", c, bus.resp_valid); end
    end
    issue_read(32'h4);
    @(negedge clk);
    checks++;
    if (bus.resp_valid !== 1'b1 || bus.data_out !== word_val(1)) begin
      errors++;
      $display("FAIL midrst_read: valid=%b data=%h, expected valid=1 data=%h", bus.resp_valid, bus.data_out, word_val(1));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion before 200000");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    idle_inputs();
    bus.resp_ready = 1'b0;
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_back_pressure();
    test_errors();
    test_simultaneous();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
